// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to instruction
// memory and drives the IF/ID register with stall, redirect and halt handling.
//
// state  | meaning
// REQ    | issue a read for pc on the next edge
// WAIT   | read outstanding, accept response into IF/ID (or HOLD when stalled)
// HOLD   | response buffered while decode is stalled
// SQUASH | redirected with a read outstanding, drop its response
// HALT   | fetching stopped until reset
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_brTaken,
    input  logic [15:0] i_brTarget,
    input  logic        i_hltSeen,
    output logic [15:0] o_imemAddr,
    output logic        o_imemRdEn,
    input  logic [15:0] i_imemData,
    input  logic        i_imemValid,
    output logic [15:0] o_instr,
    output logic [15:0] o_pcPlus1,
    output logic        o_valid
);

    typedef enum logic [2:0] {
        REQ    = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        SQUASH = 3'd3,
        HALT   = 3'd4
    } fetchState_t;

    fetchState_t state, stateNxt;
    logic [15:0] pc, pcNxt;
    logic [15:0] addrNxt;
    logic        rdEnNxt;
    logic [15:0] instrNxt;
    logic [15:0] pcPlus1Nxt;
    logic        validNxt;
    logic [15:0] holdBuf, holdBufNxt;
    logic [15:0] pcInc;

    assign pcInc = pc + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            o_imemAddr <= RESET_PC;
            o_imemRdEn <= 1'b0;
            o_instr    <= NOP_INSTR;
            o_pcPlus1  <= 16'h0000;
            o_valid    <= 1'b0;
            holdBuf    <= 16'h0000;
        end else begin
            state      <= stateNxt;
            pc         <= pcNxt;
            o_imemAddr <= addrNxt;
            o_imemRdEn <= rdEnNxt;
            o_instr    <= instrNxt;
            o_pcPlus1  <= pcPlus1Nxt;
            o_valid    <= validNxt;
            holdBuf    <= holdBufNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        pcNxt      = pc;
        addrNxt    = o_imemAddr;
        rdEnNxt    = 1'b0;
        instrNxt   = o_instr;
        pcPlus1Nxt = o_pcPlus1;
        validNxt   = o_valid;
        holdBufNxt = holdBuf;

        // No new word this cycle: bubble unless decode is holding IF/ID.
        if (!i_stall) begin
            validNxt = 1'b0;
            instrNxt = NOP_INSTR;
        end

        if (state != HALT && i_brTaken) begin
            validNxt = 1'b0;
            instrNxt = NOP_INSTR;
            pcNxt    = i_brTarget;
            if ((state == WAIT || state == SQUASH) && !i_imemValid)
                stateNxt = SQUASH;
            else
                stateNxt = REQ;
        end else if (state != HALT && i_hltSeen) begin
            stateNxt = HALT;
        end else begin
            case (state)
                REQ: begin
                    rdEnNxt  = 1'b1;
                    addrNxt  = pc;
                    stateNxt = WAIT;
                end
                WAIT: begin
                    if (i_imemValid && i_stall) begin
                        holdBufNxt = i_imemData;
                        stateNxt   = HOLD;
                    end else if (i_imemValid) begin
                        // Deliver and launch the next read on the same edge to keep
                        // one instruction per (latency + 1) cycles.
                        instrNxt   = i_imemData;
                        pcPlus1Nxt = pcInc;
                        validNxt   = 1'b1;
                        pcNxt      = pcInc;
                        rdEnNxt    = 1'b1;
                        addrNxt    = pcInc;
                        stateNxt   = WAIT;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        instrNxt   = holdBuf;
                        pcPlus1Nxt = pcInc;
                        validNxt   = 1'b1;
                        pcNxt      = pcInc;
                        rdEnNxt    = 1'b1;
                        addrNxt    = pcInc;
                        stateNxt   = WAIT;
                    end
                end
                SQUASH: begin
                    if (i_imemValid)
                        stateNxt = REQ;
                end
                HALT: begin
                    stateNxt = HALT;
                end
                default: begin
                    stateNxt = REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-1 memory models, stall/redirect/halt/reset
// sequences, plus a second instance exercising PC wrap from RESET_PC=16'hFFFF.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        stall, brTaken, hltSeen;
    logic [15:0] brTarget;
    logic [15:0] addr0, addr1, instr0, instr1, pcP10, pcP11;
    logic        rdEn0, rdEn1, valid0, valid1;
    logic [15:0] mData0, mData1;
    logic        mValid0, mValid1;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_stall(stall), .i_brTaken(brTaken),
        .i_brTarget(brTarget), .i_hltSeen(hltSeen), .o_imemAddr(addr0),
        .o_imemRdEn(rdEn0), .i_imemData(mData0), .i_imemValid(mValid0),
        .o_instr(instr0), .o_pcPlus1(pcP10), .o_valid(valid0)
    );

    fetch_stage #(.RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_stall(zero1), .i_brTaken(zero1),
        .i_brTarget(zero16), .i_hltSeen(zero1), .o_imemAddr(addr1),
        .o_imemRdEn(rdEn1), .i_imemData(mData1), .i_imemValid(mValid1),
        .o_instr(instr1), .o_pcPlus1(pcP11), .o_valid(valid1)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Latency-1 memories: response visible the cycle after the read pulse.
    always @(posedge clk) begin
        mValid0 <= rdEn0;
        mData0  <= memWord(addr0);
        mValid1 <= rdEn1;
        mData1  <= memWord(addr1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] cw;
        stall = 0; brTaken = 0; hltSeen = 0; brTarget = 16'h0000;
        rst0 = 1; rst1 = 1;
        repeat (3) tick();
        rst0 = 0; rst1 = 0;

        check("rst rdEn", {15'd0, rdEn0}, 16'd0);
        check("rst addr", addr0, 16'h0000);
        check("rst valid", {15'd0, valid0}, 16'd0);
        check("rst instr", instr0, 16'h0000);
        check("rst pcP1", pcP10, 16'h0000);
        check("rst addr wrap inst", addr1, 16'hFFFF);

        // Test 1: fetches at cycles 1,3,5,7 with bubbles between.
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c % 2 == 1) begin
                cw = 16'((c - 1) / 2);
                check($sformatf("t1 rdEn c%0d", c), {15'd0, rdEn0}, 16'd1);
                check($sformatf("t1 addr c%0d", c), addr0, cw);
                if (c >= 3) begin
                    check($sformatf("t1 valid c%0d", c), {15'd0, valid0}, 16'd1);
                    check($sformatf("t1 instr c%0d", c), instr0, memWord(16'((c - 3) / 2)));
                    check($sformatf("t1 pcP1 c%0d", c), pcP10, cw);
                end else begin
                    check($sformatf("t1 valid c%0d", c), {15'd0, valid0}, 16'd0);
                end
            end else begin
                check($sformatf("t1 rdEn c%0d", c), {15'd0, rdEn0}, 16'd0);
                check($sformatf("t1 bubble c%0d", c), {15'd0, valid0}, 16'd0);
                check($sformatf("t1 nop c%0d", c), instr0, 16'h0000);
            end
            if (c == 1) check("t5 addr first", addr1, 16'hFFFF);
            if (c == 3) begin
                check("t5 valid", {15'd0, valid1}, 16'd1);
                check("t5 instr", instr1, memWord(16'hFFFF));
                check("t5 pcP1 wrap", pcP11, 16'h0000);
                check("t5 rdEn second", {15'd0, rdEn1}, 16'd1);
                check("t5 addr second", addr1, 16'h0000);
            end
        end

        // Test 2: stall across the response for address 3.
        stall = 1;
        for (int c = 8; c <= 11; c++) begin
            tick();
            check($sformatf("t2 held valid c%0d", c), {15'd0, valid0}, 16'd1);
            check($sformatf("t2 held instr c%0d", c), instr0, memWord(16'd2));
            check($sformatf("t2 no reread c%0d", c), {15'd0, rdEn0}, 16'd0);
            if (c == 11) stall = 0;
        end
        tick();
        check("t2 release valid", {15'd0, valid0}, 16'd1);
        check("t2 release instr", instr0, memWord(16'd3));
        check("t2 release pcP1", pcP10, 16'd4);
        check("t2 next addr", addr0, 16'd4);
        check("t2 next rdEn", {15'd0, rdEn0}, 16'd1);
        tick();
        check("t2 bubble", {15'd0, valid0}, 16'd0);
        tick();
        check("t3 pre instr", instr0, memWord(16'd4));
        check("t3 pre addr", addr0, 16'd5);

        // Test 3: redirect with the read of 0x0005 outstanding.
        brTaken = 1; brTarget = 16'h0040;
        tick();
        brTaken = 0;
        check("t3 redirect valid", {15'd0, valid0}, 16'd0);
        check("t3 redirect instr", instr0, 16'h0000);
        check("t3 redirect rdEn", {15'd0, rdEn0}, 16'd0);
        tick();
        check("t3 dropped valid", {15'd0, valid0}, 16'd0);
        check("t3 dropped rdEn", {15'd0, rdEn0}, 16'd0);
        tick();
        check("t3 target rdEn", {15'd0, rdEn0}, 16'd1);
        check("t3 target addr", addr0, 16'h0040);
        check("t3 wait valid", {15'd0, valid0}, 16'd0);
        tick();
        check("t3 wait2 valid", {15'd0, valid0}, 16'd0);
        tick();
        check("t3 target valid", {15'd0, valid0}, 16'd1);
        check("t3 target instr", instr0, memWord(16'h0040));
        check("t3 target pcP1", pcP10, 16'h0041);

        // Test 4b: halt and redirect together -> redirect wins.
        brTaken = 1; brTarget = 16'h0080; hltSeen = 1;
        tick();
        brTaken = 0; hltSeen = 0;
        check("t4 br+hlt valid", {15'd0, valid0}, 16'd0);
        tick();
        check("t4 br+hlt rdEn idle", {15'd0, rdEn0}, 16'd0);
        tick();
        check("t4 br+hlt rdEn", {15'd0, rdEn0}, 16'd1);
        check("t4 br+hlt addr", addr0, 16'h0080);
        tick();
        tick();
        check("t4 br+hlt instr", instr0, memWord(16'h0080));
        check("t4 br+hlt pcP1", pcP10, 16'h0081);

        // Test 4a: halt while stalled.
        stall = 1; hltSeen = 1;
        tick();
        check("t4 halt held valid", {15'd0, valid0}, 16'd1);
        check("t4 halt held instr", instr0, memWord(16'h0080));
        check("t4 halt rdEn", {15'd0, rdEn0}, 16'd0);
        tick();
        check("t4 halt held2", {15'd0, valid0}, 16'd1);
        stall = 0;
        tick();
        hltSeen = 0;
        check("t4 halt bubble", {15'd0, valid0}, 16'd0);
        check("t4 halt nop", instr0, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t4 sticky rdEn %0d", c), {15'd0, rdEn0}, 16'd0);
            check($sformatf("t4 sticky valid %0d", c), {15'd0, valid0}, 16'd0);
        end

        // Test 6: reset mid-request discards the late response.
        rst0 = 1;
        tick();
        rst0 = 0;
        tick();
        check("t6 first rdEn", {15'd0, rdEn0}, 16'd1);
        check("t6 first addr", addr0, 16'h0000);
        rst0 = 1;
        tick();
        rst0 = 0;
        check("t6 reset rdEn", {15'd0, rdEn0}, 16'd0);
        check("t6 reset valid", {15'd0, valid0}, 16'd0);
        tick();
        check("t6 restart rdEn", {15'd0, rdEn0}, 16'd1);
        check("t6 restart addr", addr0, 16'h0000);
        check("t6 late ignored", {15'd0, valid0}, 16'd0);
        tick();
        check("t6 wait valid", {15'd0, valid0}, 16'd0);
        tick();
        check("t6 fetch valid", {15'd0, valid0}, 16'd1);
        check("t6 fetch instr", instr0, memWord(16'h0000));
        check("t6 fetch pcP1", pcP10, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
